// File: rtl/led_pwm_if.sv
// LED PIO side bundle for led_pwm_driver: logical enables, per-channel modes and
// brightness in, pin drive, readback state and frame strobe out.
interface led_pwm_if #(
  parameter int WIDTH    = 4,
  parameter int PWM_BITS = 8
);
  logic [WIDTH-1:0]    led_in;
  logic [2*WIDTH-1:0]  mode;
  logic [PWM_BITS-1:0] brightness;
  logic [WIDTH-1:0]    led_out;
  logic [WIDTH-1:0]    led_state;
  logic                frame_start;

  modport master (
    output led_in, mode, brightness,
    input  led_out, led_state, frame_start
  );

  modport slave (
    input  led_in, mode, brightness,
    output led_out, led_state, frame_start
  );
endinterface

// File: rtl/led_pwm_driver.sv
// Drives board LEDs from the PIO out_port with per-channel steady/blink/breathe PWM,
// returning the logical (pre-PWM) LED state for in_port readback.
module led_pwm_driver #(
  parameter int WIDTH        = 4,
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 196,
  parameter int BLINK_FRAMES = 250,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  led_pwm_if.slave bus
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [BF_W-1:0]     BF_LAST = BF_W'(BLINK_FRAMES - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic [WIDTH-1:0]    PIN_OFF = {WIDTH{ACTIVE_LOW}};

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] breathe_duty;
  logic                breathe_dir;
  logic [BF_W-1:0]     blink_cnt;
  logic                blink_phase;

  logic                tick_p0;
  logic                frame_wrap_p0;
  logic [WIDTH-1:0]    le_p0;
  logic [WIDTH-1:0]    on_p0;

  logic [WIDTH-1:0]    led_out_p1;
  logic [WIDTH-1:0]    led_state_p1;
  logic                frame_start_p1;

  // Triangle ramp step: the endpoint frame is held once while direction turns,
  // so the ramp never wraps. Returns {next_dir, next_duty}.
  function automatic logic [PWM_BITS:0] breathe_step(input logic [PWM_BITS-1:0] duty,
                                                     input logic dir);
    logic [PWM_BITS:0] nxt;
    if (!dir && duty == PWM_MAX) begin
      nxt = {1'b1, duty};
    end else if (dir && duty == '0) begin
      nxt = {1'b0, duty};
    end else if (dir) begin
      nxt = {1'b1, duty - PWM_BITS'(1)};
    end else begin
      nxt = {1'b0, duty + PWM_BITS'(1)};
    end
    return nxt;
  endfunction

  // Stage p0: counter decode and per-channel enable/compare
  always_comb begin
    tick_p0       = (prescaler == PS_LAST);
    frame_wrap_p0 = tick_p0 && (pwm_cnt == PWM_MAX);
    le_p0         = '0;
    on_p0         = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (bus.mode[2*i +: 2])
        2'b01, 2'b11: le_p0[i] = bus.led_in[i];
        2'b10:        le_p0[i] = bus.led_in[i] & blink_phase;
        default:      le_p0[i] = 1'b0;
      endcase
      on_p0[i] = le_p0[i] &&
                 (pwm_cnt < ((bus.mode[2*i +: 2] == 2'b11) ? breathe_duty : duty_q));
    end
  end

  // Stage p1: counters advance, outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler      <= '0;
      pwm_cnt        <= '0;
      duty_q         <= '0;
      breathe_duty   <= '0;
      breathe_dir    <= 1'b0;
      blink_cnt      <= '0;
      blink_phase    <= 1'b0;
      led_out_p1     <= PIN_OFF;
      led_state_p1   <= '0;
      frame_start_p1 <= 1'b0;
    end else begin
      prescaler <= tick_p0 ? '0 : prescaler + PS_W'(1);
      if (tick_p0) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
      // Brightness is only taken at the frame boundary so no frame is ever split.
      if (frame_wrap_p0) begin
        duty_q                      <= bus.brightness;
        {breathe_dir, breathe_duty} <= breathe_step(breathe_duty, breathe_dir);
        if (blink_cnt == BF_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BF_W'(1);
        end
      end
      led_state_p1   <= le_p0;
      led_out_p1     <= on_p0 ^ PIN_OFF;
      frame_start_p1 <= frame_wrap_p0;
    end
  end

  assign bus.led_out     = led_out_p1;
  assign bus.led_state   = led_state_p1;
  assign bus.frame_start = frame_start_p1;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: two configurations checked every cycle against a
// frame-arithmetic model, plus hand-computed duty, blink and breathe expectations.
module tb_led_pwm_driver;

  localparam int PA = 1, BA = 8, BFA = 2;
  localparam bit ALA = 1'b0;
  localparam int PB = 3, BB = 4, BFB = 1;
  localparam bit ALB = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_pwm_if #(.WIDTH(4), .PWM_BITS(BA)) if_a ();
  led_pwm_if #(.WIDTH(4), .PWM_BITS(BB)) if_b ();

  led_pwm_driver #(.WIDTH(4), .PWM_BITS(BA), .PRESCALE(PA), .BLINK_FRAMES(BFA),
                   .ACTIVE_LOW(ALA)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  led_pwm_driver #(.WIDTH(4), .PWM_BITS(BB), .PRESCALE(PB), .BLINK_FRAMES(BFB),
                   .ACTIVE_LOW(ALB)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: everything follows from the cycle count t since reset release.
  function automatic int tri_duty(input int f, input int b);
    int k;
    k = f % (2 << b);
    return (k < (1 << b)) ? k : (2 << b) - 1 - k;
  endfunction

  function automatic logic [3:0] m_le(input int t, input int p, input int b, input int bf,
                                      input logic [7:0] md, input logic [3:0] li);
    logic [3:0] le;
    int f;
    logic ph;
    f  = t / (p << b);
    ph = ((f / bf) % 2) == 1;
    for (int i = 0; i < 4; i++) begin
      case (md[2*i +: 2])
        2'b00:   le[i] = 1'b0;
        2'b10:   le[i] = li[i] & ph;
        default: le[i] = li[i];
      endcase
    end
    return le;
  endfunction

  function automatic logic [3:0] m_on(input int t, input int p, input int b, input int bf,
                                      input logic [7:0] md, input logic [3:0] li,
                                      input int dq);
    logic [3:0] le, on;
    int pc, d;
    le = m_le(t, p, b, bf, md, li);
    pc = (t / p) % (1 << b);
    for (int i = 0; i < 4; i++) begin
      d     = (md[2*i +: 2] == 2'b11) ? tri_duty(t / (p << b), b) : dq;
      on[i] = le[i] && (pc < d);
    end
    return on;
  endfunction

  function automatic bit m_wrap(input int t, input int p, input int b);
    return (t % (p << b)) == (p << b) - 1;
  endfunction

  int ta, tb_t, dqa, dqb;
  logic [3:0] ea_out, ea_st, eb_out, eb_st;
  logic ea_fs, eb_fs;
  bit m_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      ta <= 0; tb_t <= 0; dqa <= 0; dqb <= 0;
      ea_out <= {4{ALA}}; ea_st <= 4'b0; ea_fs <= 1'b0;
      eb_out <= {4{ALB}}; eb_st <= 4'b0; eb_fs <= 1'b0;
      m_ok <= 1'b1;
    end else begin
      ta     <= ta + 1;
      ea_st  <= m_le(ta, PA, BA, BFA, if_a.mode, if_a.led_in);
      ea_out <= m_on(ta, PA, BA, BFA, if_a.mode, if_a.led_in, dqa) ^ {4{ALA}};
      ea_fs  <= m_wrap(ta, PA, BA);
      if (m_wrap(ta, PA, BA)) dqa <= int'(if_a.brightness);
      tb_t   <= tb_t + 1;
      eb_st  <= m_le(tb_t, PB, BB, BFB, if_b.mode, if_b.led_in);
      eb_out <= m_on(tb_t, PB, BB, BFB, if_b.mode, if_b.led_in, dqb) ^ {4{ALB}};
      eb_fs  <= m_wrap(tb_t, PB, BB);
      if (m_wrap(tb_t, PB, BB)) dqb <= int'(if_b.brightness);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("a_led_out", if_a.led_out, ea_out);
      chk("a_led_state", if_a.led_state, ea_st);
      chk("a_frame_start", if_a.frame_start, ea_fs);
      chk("b_led_out", if_b.led_out, eb_out);
      chk("b_led_state", if_b.led_state, eb_st);
      chk("b_frame_start", if_b.frame_start, eb_fs);
    end
  end

  int cnt_a[4];

  task automatic count_a(input int n);
    for (int c = 0; c < 4; c++) cnt_a[c] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (if_a.led_out[c]) cnt_a[c]++;
    end
  endtask

  bit rel1 = 1'b0;
  bit b_done = 1'b0;
  int bd_exp[34] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                     15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0,
                     0, 1, 2};

  // Breathe channel on the active-low, prescaled instance: high time per frame.
  initial begin
    int n, c;
    wait (rel1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_b.frame_start && n < 500);
    chk("b_first_frame_start", n, 48);
    for (int f = 0; f < 34; f++) begin
      c = 0;
      for (int k = 0; k < 48; k++) begin
        @(negedge clk);
        if (!if_b.led_out[0]) c++;
      end
      chk($sformatf("breathe_frame%0d", f + 1), c, 3 * bd_exp[f]);
    end
    b_done = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    if_a.mode = 8'h55; if_a.led_in = 4'b0101; if_a.brightness = 8'd64;
    if_b.mode = 8'hFF; if_b.led_in = 4'b1111; if_b.brightness = 4'd9;
    repeat (3) @(negedge clk);
    chk("rst_b_led_out", if_b.led_out, 4'b1111);
    chk("rst_b_led_state", if_b.led_state, 4'b0000);
    chk("rst_b_frame_start", if_b.frame_start, 0);
    chk("rst_a_led_out", if_a.led_out, 4'b0000);
    reset = 1'b0;
    rel1  = 1'b1;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_a.frame_start && n < 2000);
    chk("a_first_frame_start", n, 256);

    count_a(256);
    chk("steady_ch0_64", cnt_a[0], 64);
    chk("steady_ch1_off", cnt_a[1], 0);
    chk("steady_ch2_64", cnt_a[2], 64);
    chk("steady_ch3_off", cnt_a[3], 0);
    chk("steady_led_state", if_a.led_state, 4'b0101);

    fork
      count_a(256);
      begin
        repeat (100) @(negedge clk);
        if_a.brightness = 8'd192;
      end
    join
    chk("midframe_change_keeps_64", cnt_a[0], 64);
    count_a(256);
    chk("next_frame_192", cnt_a[0], 192);

    if_a.brightness = 8'd0;
    count_a(256);
    chk("pre_zero_frame_192", cnt_a[0], 192);
    count_a(256);
    chk("bright_0_off", cnt_a[0], 0);
    if_a.brightness = 8'd255;
    count_a(256);
    chk("pre_max_frame_0", cnt_a[0], 0);
    count_a(256);
    chk("bright_255", cnt_a[0], 255);

    n = 0;
    while (!b_done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("breathe_done", b_done, 1);

    // Blink from power-up, then a one-cycle reset in the middle of an on frame.
    reset = 1'b1;
    if_a.mode = 8'h02; if_a.led_in = 4'b0001; if_a.brightness = 8'd255;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    count_a(512);
    chk("blink_off_first", cnt_a[0], 0);
    chk("blink_off_state", if_a.led_state, 4'b0000);
    count_a(512);
    chk("blink_on_first", cnt_a[0], 510);
    count_a(512);
    chk("blink_off_second", cnt_a[0], 0);
    count_a(300);
    chk("blink_on_partial", cnt_a[0], 299);
    chk("blink_on_state", if_a.led_state, 4'b0001);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_led_out", if_a.led_out, 4'b0000);
    chk("midreset_led_state", if_a.led_state, 4'b0000);
    chk("midreset_frame_start", if_a.frame_start, 0);
    reset = 1'b0;
    count_a(512);
    chk("restart_blink_off", cnt_a[0], 0);
    count_a(512);
    chk("restart_blink_on", cnt_a[0], 510);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
